// File: rtl/scr_pkg.sv
// scr_pkg: screen character RAM layout constants, control codes and writer state
package scr_pkg;
  localparam int SCR_ROWS = 24;
  localparam int SCR_COLS = 32;
  localparam int SCR_BLK_SIZE = SCR_ROWS * SCR_COLS;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CLR = 8'h0C;
  localparam logic [7:0] CH_BS = 8'h08;
  typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/scr_addr_calc.sv
// scr_addr_calc: column-major cell address, screen*ROWS*COLS + x*ROWS + y
module scr_addr_calc #(
  parameter int ROWS = 24,
  parameter int COLS = 32
) (
  input  logic [3:0]  screen_i,
  input  logic [4:0]  x_i,
  input  logic [4:0]  y_i,
  output logic [13:0] addr_o
);
  assign addr_o = 14'(screen_i) * 14'(ROWS * COLS) + 14'(x_i) * 14'(ROWS) + 14'(y_i);
endmodule

// File: rtl/screen_char_writer.sv
// screen_char_writer: cursor-driven character RAM writer with clear-screen; SCR_WRITER_BACKSPACE_EN enables 8'h08 backspace
module screen_char_writer #(
  parameter int SCR_ROWS = 24,
  parameter int SCR_COLS = 32,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  screen,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);
  import scr_pkg::*;
  localparam int BLK = SCR_ROWS * SCR_COLS;
  localparam logic [4:0] YMAX = 5'(SCR_ROWS - 1);
  localparam logic [4:0] XMAX = 5'(SCR_COLS - 1);
  state_e state_q;
  logic [4:0] x_q, y_q, nx, ny, px, py, cx, cy;
  logic [3:0] scr_q;
  logic [9:0] cnt_q;
  logic [13:0] cell_addr, base_addr, wr_addr_q;
  logic [7:0] wr_data_q;
  logic wr_en_q, in_ready_q, busy_q, accept, is_bs;
`ifdef SCR_WRITER_BACKSPACE_EN
  assign is_bs = in_char == CH_BS;
`else
  assign is_bs = 1'b0;
`endif
  assign accept = in_valid && in_ready_q;
  assign ny = y_q == YMAX ? 5'd0 : y_q + 5'd1;
  assign nx = y_q != YMAX ? x_q : x_q == XMAX ? 5'd0 : x_q + 5'd1;
  assign py = y_q == 5'd0 ? YMAX : y_q - 5'd1;
  assign px = y_q != 5'd0 ? x_q : x_q == 5'd0 ? XMAX : x_q - 5'd1;
  assign cx = is_bs ? px : x_q;
  assign cy = is_bs ? py : y_q;
  scr_addr_calc #(.ROWS(SCR_ROWS), .COLS(SCR_COLS)) u_cell (
    .screen_i(screen), .x_i(cx), .y_i(cy), .addr_o(cell_addr)
  );
  scr_addr_calc #(.ROWS(SCR_ROWS), .COLS(SCR_COLS)) u_base (
    .screen_i(state_q == CLEAR ? scr_q : screen), .x_i(5'd0), .y_i(5'd0), .addr_o(base_addr)
  );
  // Writer FSM: cursor moves and one write per printable code, linear sweep during clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      wr_en_q <= cnt_q != 10'(BLK);
      wr_addr_q <= base_addr + 14'(cnt_q);
      cnt_q <= cnt_q + 10'd1;
      if (cnt_q == 10'(BLK)) begin
        state_q <= IDLE;
        in_ready_q <= 1'b1;
        busy_q <= 1'b0;
        x_q <= '0;
        y_q <= '0;
      end
    end else begin
      in_ready_q <= 1'b1;
      wr_en_q <= accept && in_char != CH_NL;
      if (accept && in_char == CH_CLR) begin
        state_q <= CLEAR;
        scr_q <= screen;
        cnt_q <= 10'd1;
        in_ready_q <= 1'b0;
        busy_q <= 1'b1;
        wr_addr_q <= base_addr;
        wr_data_q <= CLEAR_CHAR;
      end else if (accept && in_char == CH_NL) begin
        y_q <= ny;
      end else if (accept) begin
        wr_addr_q <= cell_addr;
        wr_data_q <= is_bs ? CLEAR_CHAR : in_char;
        x_q <= is_bs ? px : nx;
        y_q <= is_bs ? py : ny;
      end
    end
  end
  assign in_ready = in_ready_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cursor_x = x_q;
  assign cursor_y = y_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_screen_char_writer.sv
// tb_screen_char_writer: directed vector table plus clear, wrap, newline and reset-abort sequences
module tb_screen_char_writer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, wr_en, busy;
  logic [3:0] screen = '0;
  logic [7:0] in_char = '0, wr_data;
  logic [13:0] wr_addr;
  logic [4:0] cursor_x, cursor_y;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] s;
    logic [7:0] c;
    logic we;
    logic [13:0] a;
    logic [7:0] d;
    logic [4:0] x;
    logic [4:0] y;
  } vec_t;
  vec_t vecs[7];
  screen_char_writer dut (
    .clk(clk), .rst_n(rst_n), .screen(screen), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] s, input logic [7:0] c);
    @(negedge clk);
    screen = s;
    in_char = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic stream(input logic [3:0] s, input logic [7:0] c, input int n);
    @(negedge clk);
    screen = s;
    in_char = c;
    in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    int bad;
    vecs[0] = '{4'd0, 8'h41, 1'b1, 14'd0, 8'h41, 5'd0, 5'd1};
    vecs[1] = '{4'd0, 8'h0A, 1'b0, 14'd0, 8'h00, 5'd0, 5'd2};
    vecs[2] = '{4'd3, 8'h42, 1'b1, 14'd2306, 8'h42, 5'd0, 5'd3};
    vecs[3] = '{4'd15, 8'h7E, 1'b1, 14'd11523, 8'h7E, 5'd0, 5'd4};
    vecs[4] = '{4'd0, 8'h0A, 1'b0, 14'd0, 8'h00, 5'd0, 5'd5};
    vecs[5] = '{4'd7, 8'h00, 1'b1, 14'd5381, 8'h00, 5'd0, 5'd6};
`ifdef SCR_WRITER_BACKSPACE_EN
    vecs[6] = '{4'd0, 8'h08, 1'b1, 14'd5, 8'h20, 5'd0, 5'd5};
`else
    vecs[6] = '{4'd0, 8'h08, 1'b1, 14'd6, 8'h08, 5'd0, 5'd7};
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", {cursor_x, cursor_y}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", in_ready, 1);
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].s, vecs[i].c);
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), wr_addr, vecs[i].a);
        chk($sformatf("vec%0d_data", i), wr_data, vecs[i].d);
      end
      chk($sformatf("vec%0d_cursor", i), {cursor_x, cursor_y}, {vecs[i].x, vecs[i].y});
      @(posedge clk);
      #1 chk($sformatf("vec%0d_strobe_1cyc", i), wr_en, 0);
    end
    send(4'd1, 8'h0C);
    screen = 4'd9;
    bad = 0;
    for (int k = 0; k < 768; k++) begin
      if (!(wr_en === 1'b1 && wr_addr === 14'(768 + k) && wr_data === 8'h20 && in_ready === 1'b0 && busy === 1'b1)) bad++;
      @(posedge clk);
      #1;
    end
    chk("clear_sweep_bad_cycles", bad, 0);
    chk("clear_end_ready", in_ready, 1);
    chk("clear_end_busy", busy, 0);
    chk("clear_end_wr_en", wr_en, 0);
    chk("clear_end_cursor", {cursor_x, cursor_y}, 0);
    @(negedge clk);
    screen = 4'd2;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      in_char = 8'(8'h30 + i);
      @(posedge clk);
      #1;
      if (!(wr_en === 1'b1 && wr_addr === 14'(1536 + i) && wr_data === 8'(8'h30 + i))) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("run24_bad", bad, 0);
    chk("run24_cursor", {cursor_x, cursor_y}, {5'd1, 5'd0});
    stream(4'd0, 8'h41, 743);
    chk("pre_wrap_cursor", {cursor_x, cursor_y}, {5'd31, 5'd23});
    send(4'd15, 8'h5A);
    chk("wrap_addr", wr_addr, 12287);
    chk("wrap_data", wr_data, 8'h5A);
    chk("wrap_cursor", {cursor_x, cursor_y}, 0);
    stream(4'd0, 8'h41, 143);
    chk("pre_nl_cursor", {cursor_x, cursor_y}, {5'd5, 5'd23});
    send(4'd0, 8'h0A);
    chk("nl_wr_en", wr_en, 0);
    chk("nl_cursor", {cursor_x, cursor_y}, {5'd5, 5'd0});
    send(4'd4, 8'h0C);
    repeat (99) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("abort_ready_back", in_ready, 1);
    send(4'd0, 8'h41);
    chk("abort_idle_addr", wr_addr, 0);
    chk("abort_idle_wr_en", wr_en, 1);
`ifdef SCR_WRITER_BACKSPACE_EN
    send(4'd0, 8'h0C);
    for (int i = 0; i < 800 && in_ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bs_clear_done", in_ready, 1);
    send(4'd0, 8'h08);
    chk("bs_wr_en", wr_en, 1);
    chk("bs_addr", wr_addr, 767);
    chk("bs_data", wr_data, 8'h20);
    chk("bs_cursor", {cursor_x, cursor_y}, {5'd31, 5'd23});
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
